// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point multiplier output path:
// default field widths, flag bit positions and the flag vector type.
package fp_pkg;

  localparam int E_DEF    = 8;
  localparam int M_DEF    = 23;
  localparam int BITS_DEF = 1 + E_DEF + M_DEF;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_UNDER = 1;
  localparam int FLG_OVER  = 2;
  localparam int FLG_NAN   = 3;

  typedef logic [3:0] flags_t;

  // Underflow, overflow and nan count as exceptions; an exact zero does not.
  function automatic logic is_exception(input flags_t f);
    return f[FLG_UNDER] | f[FLG_OVER] | f[FLG_NAN];
  endfunction

endpackage

// File: rtl/fp_canon.sv
// Combinational canonicaliser: rewrites flagged multiplier results to the
// canonical IEEE encoding, keeping the sign of the raw product.
module fp_canon
  import fp_pkg::*;
#(
  parameter int E = E_DEF,
  parameter int M = M_DEF,
  localparam int BITS = 1 + E + M
) (
  input  logic [BITS-1:0] result,
  input  logic            zero,
  input  logic            underflow,
  input  logic            overflow,
  input  logic            nan,
  output logic [BITS-1:0] canon
);

  logic sign;

  assign sign = result[BITS-1];

  // NOTE: every branch assigns canon, so no latch is inferred.
  always_comb begin
    canon = result;
    if (nan)
      canon = {sign, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    else if (overflow)
      canon = {sign, {E{1'b1}}, {M{1'b0}}};
    else if (underflow || zero)
      canon = {sign, {(BITS-1){1'b0}}};
  end

endmodule

// File: rtl/fp_result_fifo.sv
// Output stage for the FP multiplier: canonicalises each product, buffers it
// in a show-ahead FIFO and tracks sticky exception flags plus a saturating count.
module fp_result_fifo
  import fp_pkg::*;
#(
  parameter int E     = E_DEF,
  parameter int M     = M_DEF,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16,
  localparam int BITS = 1 + E + M,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_result,
  input  logic            in_zero,
  input  logic            in_underflow,
  input  logic            in_overflow,
  input  logic            in_nan,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_result,
  output logic [3:0]      out_flags,
  output logic [CW-1:0]   count,
  output logic [3:0]      sticky_flags,
  input  logic            clr_sticky,
  output logic [CNTW-1:0] exc_cnt
);

  localparam logic [1:0] OCC_EMPTY   = 2'd0;
  localparam logic [1:0] OCC_PARTIAL = 2'd1;
  localparam logic [1:0] OCC_FULL    = 2'd2;

  logic [BITS+3:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [1:0]      occ;
  logic            push;
  logic            pop;
  flags_t          in_flags;
  logic [BITS-1:0] canon_word;

  assign in_flags = {in_nan, in_overflow, in_underflow, in_zero};

  fp_canon #(.E(E), .M(M)) u_canon (
    .result    (in_result),
    .zero      (in_zero),
    .underflow (in_underflow),
    .overflow  (in_overflow),
    .nan       (in_nan),
    .canon     (canon_word)
  );

  // Occupancy is decoded from the registered count only, so in_ready and
  // out_valid never depend combinationally on in_valid or out_ready.
  always_comb begin
    occ = OCC_PARTIAL;
    if (count == '0)
      occ = OCC_EMPTY;
    else if (count == CW'(DEPTH))
      occ = OCC_FULL;
  end

  assign in_ready = (occ != OCC_FULL);
  assign out_valid = (occ != OCC_EMPTY);
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  assign out_result = mem[rd_ptr][BITS-1:0];
  assign out_flags = mem[rd_ptr][BITS+3:BITS];

  // NOTE: storage has no reset; count gates every read, so stale contents are
  // never observed and the array can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {in_flags, canon_word};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A push in the same cycle as a clear survives: the clear only drops history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_flags <= '0;
    end else if (clr_sticky && push) begin
      sticky_flags <= in_flags;
    end else if (clr_sticky) begin
      sticky_flags <= '0;
    end else if (push) begin
      sticky_flags <= sticky_flags | in_flags;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      exc_cnt <= '0;
    else if (push && is_exception(in_flags) && (exc_cnt != {CNTW{1'b1}}))
      exc_cnt <= exc_cnt + CNTW'(1);
  end

endmodule
